vga_pattern_gen: RTL and testbench

//   Parametrised multi-mode VGA test pattern generator; successor to the fixed 640x480 bar generator.

---
 rtl/vga_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test pattern generator.
// Tracks pixel/line/frame position from the timing block's active strobes and
// produces a registered RGB pixel plus an aligned data-enable.
module vga_pattern_gen #(
  parameter int COLOR_BITS  = 4,
  parameter int CNT_W       = 12,
  parameter int NUM_BARS    = 8,
  parameter int CHECK_LOG2  = 5,
  parameter int STRIPE_LOG2 = 4,
  parameter int RAMP_SHIFT  = 2
) (
  input  logic                    pxl_clk,
  input  logic                    pxl_rst_n,
  input  logic [CNT_W-1:0]        horz_res,
  input  logic [CNT_W-1:0]        vert_res,
  input  logic [CNT_W-1:0]        bar_len,
  input  logic [2:0]              pattern_sel,
  input  logic [3*COLOR_BITS-1:0] solid_color,
  input  logic                    horz_active,
  input  logic                    vert_active,
  input  logic                    frame_active,
  output logic [COLOR_BITS-1:0]   rgb_red,
  output logic [COLOR_BITS-1:0]   rgb_green,
  output logic [COLOR_BITS-1:0]   rgb_blue,
  output logic                    rgb_de
);

  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [2:0]              LAST_BAR = 3'(NUM_BARS - 1);
  localparam logic [3*COLOR_BITS-1:0] WHITE    = '1;
  localparam logic [3*COLOR_BITS-1:0] BLACK    = '0;

  // Palette order: white, yellow, cyan, green, magenta, red, blue, black.
  // Red is off when idx[1] set, green off when idx[2] set, blue off when idx[0] set.
  function automatic logic [3*COLOR_BITS-1:0] palette(input logic [2:0] idx);
    return {{COLOR_BITS{~idx[1]}}, {COLOR_BITS{~idx[2]}}, {COLOR_BITS{~idx[0]}}};
  endfunction

  logic                    h_act_q, v_act_q;
  logic [CNT_W-1:0]        x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0]        y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]        bar_pix_q, bar_pix_d;
  logic [2:0]              bar_idx_q, bar_idx_d;
  logic [2:0]              mode_q, mode_d;
  logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
  logic                    de_q, de_d;

  logic                    h_fall, v_fall;
  logic [CNT_W-1:0]        bar_term;
  logic [2:0]              stripe_idx;
  logic [COLOR_BITS-1:0]   ramp_lvl, scroll_lvl;
  logic                    checker_on, border_on;
  logic [3*COLOR_BITS-1:0] pattern_rgb;

  // Position counters, bar counter and frame-boundary mode latch.
  always_comb begin
    h_fall      = h_act_q & ~horz_active;
    v_fall      = v_act_q & ~vert_active;

    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    frame_cnt_d = frame_cnt_q;
    bar_pix_d   = bar_pix_q;
    bar_idx_d   = bar_idx_q;
    mode_d      = mode_q;

    if (!horz_active)
      x_cnt_d = '0;
    else if (x_cnt_q != CNT_MAX)
      x_cnt_d = x_cnt_q + CNT_W'(1);

    // vert_active low wins over a coincident line end.
    if (!vert_active)
      y_cnt_d = '0;
    else if (h_fall && (y_cnt_q != CNT_MAX))
      y_cnt_d = y_cnt_q + CNT_W'(1);

    if (v_fall) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      mode_d      = pattern_sel;
    end

    // A zero bar length behaves as one pixel; >= keeps a shrinking bar_len safe mid-line.
    bar_term = (bar_len == '0) ? '0 : (bar_len - CNT_W'(1));
    if (!horz_active) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (bar_pix_q >= bar_term) begin
      bar_pix_d = '0;
      bar_idx_d = (bar_idx_q == LAST_BAR) ? 3'd0 : (bar_idx_q + 3'd1);
    end else begin
      bar_pix_d = bar_pix_q + CNT_W'(1);
    end
  end

  // Pattern colour for the current position, gated by frame_active.
  always_comb begin
    stripe_idx = 3'((y_cnt_q >> STRIPE_LOG2) % CNT_W'(NUM_BARS));
    ramp_lvl   = COLOR_BITS'(x_cnt_q >> RAMP_SHIFT);
    scroll_lvl = COLOR_BITS'((x_cnt_q + frame_cnt_q) >> RAMP_SHIFT);
    checker_on = x_cnt_q[CHECK_LOG2] ^ y_cnt_q[CHECK_LOG2];
    border_on  = (x_cnt_q == '0) || (x_cnt_q == horz_res - CNT_W'(1)) ||
                 (y_cnt_q == '0) || (y_cnt_q == vert_res - CNT_W'(1)) ||
                 (x_cnt_q == (horz_res >> 1)) || (y_cnt_q == (vert_res >> 1));

    case (mode_q)
      3'd0:    pattern_rgb = solid_color;
      3'd1:    pattern_rgb = palette(bar_idx_q);
      3'd2:    pattern_rgb = palette(stripe_idx);
      3'd3:    pattern_rgb = checker_on ? WHITE : BLACK;
      3'd4:    pattern_rgb = {3{ramp_lvl}};
      3'd5:    pattern_rgb = {3{scroll_lvl}};
      3'd6:    pattern_rgb = border_on ? WHITE : BLACK;
      default: pattern_rgb = BLACK;
    endcase

    rgb_d = frame_active ? pattern_rgb : BLACK;
    de_d  = frame_active;
  end

  // State and output registers.
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      h_act_q     <= 1'b0;
      v_act_q     <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      frame_cnt_q <= '0;
      bar_pix_q   <= '0;
      bar_idx_q   <= '0;
      mode_q      <= '0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
    end else begin
      h_act_q     <= horz_active;
      v_act_q     <= vert_active;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      bar_pix_q   <= bar_pix_d;
      bar_idx_q   <= bar_idx_d;
      mode_q      <= mode_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
    end
  end

  assign rgb_red   = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
  assign rgb_green = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign rgb_blue  = rgb_q[COLOR_BITS-1 -: COLOR_BITS];
  assign rgb_de    = de_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: drives frames of pixel timing, predicts each
// active pixel from position/frame arithmetic and checks it in a separate monitor.
module tb_vga_pattern_gen;

  logic        pxl_clk = 1'b0;
  logic        pxl_rst_n = 1'b0;
  logic [11:0] horz_res = 12'd640;
  logic [11:0] vert_res = 12'd480;
  logic [11:0] bar_len = 12'd80;
  logic [2:0]  pattern_sel = 3'd0;
  logic [11:0] solid_color = 12'h000;
  logic        horz_active = 1'b0;
  logic        vert_active = 1'b0;
  logic        frame_active = 1'b0;
  logic [3:0]  rgb_red, rgb_green, rgb_blue;
  logic        rgb_de;

  vga_pattern_gen dut (
    .pxl_clk      (pxl_clk),
    .pxl_rst_n    (pxl_rst_n),
    .horz_res     (horz_res),
    .vert_res     (vert_res),
    .bar_len      (bar_len),
    .pattern_sel  (pattern_sel),
    .solid_color  (solid_color),
    .horz_active  (horz_active),
    .vert_active  (vert_active),
    .frame_active (frame_active),
    .rgb_red      (rgb_red),
    .rgb_green    (rgb_green),
    .rgb_blue     (rgb_blue),
    .rgb_de       (rgb_de)
  );

  always #5 pxl_clk = ~pxl_clk;

  int unsigned cyc = 0;
  always @(posedge pxl_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned stamp;
    logic [11:0] rgb;
    int          x;
    int          y;
  } exp_t;
  exp_t exp_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  bit  checking = 1'b0;
  int  cur_mode = 0;
  int  frame_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference colours.
  function automatic logic [11:0] pal(input int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] grey(input int lvl);
    logic [3:0] l;
    l = 4'(lvl);
    return {l, l, l};
  endfunction

  // Expected pixel at column x, line y of frame f shown in the given mode.
  function automatic logic [11:0] model(input int mode, input int x, input int y, input int f);
    int bl, hr, vr;
    case (mode)
      0: return solid_color;
      1: begin
        bl = (bar_len == 0) ? 1 : int'(bar_len);
        return pal((x / bl) % 8);
      end
      2: return pal((y / 16) % 8);
      3: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      4: return grey((x / 4) % 16);
      5: return grey((((x + f) % 4096) / 4) % 16);
      6: begin
        hr = int'(horz_res);
        vr = int'(vert_res);
        if (x == 0 || x == hr - 1 || y == 0 || y == vr - 1 || x == hr / 2 || y == vr / 2)
          return 12'hFFF;
        return 12'h000;
      end
      default: return 12'h000;
    endcase
  endfunction

  // Present one cycle of timing strobes; active pixels get a predicted result.
  task automatic drive(input bit h, input bit v, input int x, input int y);
    exp_t e;
    @(posedge pxl_clk);
    #1;
    horz_active  = h;
    vert_active  = v;
    frame_active = h & v;
    if (h & v) begin
      e.stamp = cyc + 1;
      e.rgb   = model(cur_mode, x, y, frame_no);
      e.x     = x;
      e.y     = y;
      exp_q.push_back(e);
    end
  endtask

  // One frame; pattern_sel is changed mid-frame and must only apply to the next frame.
  task automatic run_frame(input int hact, input int lines, input int hblank,
                           input int next_sel, input int chg_line);
    bit simul;
    simul = 1'($urandom_range(0, 1));
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) pattern_sel = 3'(next_sel);
      for (int x = 0; x < hact; x++) drive(1'b1, 1'b1, x, l);
      if (l == lines - 1 && simul) drive(1'b0, 1'b0, 0, 0);
      else for (int b = 0; b < hblank; b++) drive(1'b0, 1'b1, 0, 0);
    end
    if (!simul) drive(1'b0, 1'b0, 0, 0);
    cur_mode = next_sel;
    frame_no = frame_no + 1;
    // Vertical blanking, including a line of horz_active with frame_active low.
    drive(1'b0, 1'b0, 0, 0);
    for (int x = 0; x < 12; x++) drive(1'b1, 1'b0, 0, 0);
    for (int b = 0; b < hblank + 1; b++) drive(1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: pops a prediction for every data-enabled pixel, expects black otherwise.
  always @(negedge pxl_clk) begin
    exp_t e;
    if (checking && pxl_rst_n) begin
      if (rgb_de) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_de", 32'(rgb_de), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("pixel_rgb x=%0d y=%0d mode=%0d", e.x, e.y, cur_mode),
              32'({rgb_red, rgb_green, rgb_blue}), 32'(e.rgb));
          chk("pixel_latency", cyc, e.stamp);
        end
      end else begin
        chk("blank_rgb", 32'({rgb_red, rgb_green, rgb_blue}), 32'd0);
        chk("de_missing", 32'((exp_q.size() > 0) && (exp_q[0].stamp <= cyc)), 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hact, lines;
    repeat (3) @(posedge pxl_clk);
    #2;
    chk("reset_rgb", 32'({rgb_red, rgb_green, rgb_blue}), 32'd0);
    chk("reset_de", 32'(rgb_de), 32'd0);
    pxl_rst_n = 1'b1;
    checking  = 1'b1;

    solid_color = 12'($urandom);
    run_frame(32, 6, 3, 1, 3);            // solid
    bar_len = 12'd80;
    run_frame(640, 3, 4, 1, 1);           // 640-wide bars of 80
    bar_len = 12'd0;
    run_frame(40, 110, 3, 3, 100);        // one-pixel bars; switch to checker at line 100
    run_frame(64, 40, 3, 2, 20);          // checker
    run_frame(24, 70, 2, 4, 10);          // stripes
    run_frame(80, 4, 2, 5, 1);            // ramp
    run_frame(80, 4, 2, 5, 1);            // scroll
    horz_res = 12'd48;
    vert_res = 12'd20;
    run_frame(80, 4, 2, 6, 1);            // scroll, next border
    run_frame(48, 20, 2, 6, 5);           // border, full frame visible
    horz_res = 12'd800;
    vert_res = 12'd600;
    run_frame(800, 3, 4, 7, 1);           // border, 800 wide
    run_frame(20, 3, 2, 0, 1);            // reserved

    for (int i = 0; i < 12; i++) begin
      hact        = int'($urandom_range(16, 64));
      lines       = int'($urandom_range(4, 24));
      solid_color = 12'($urandom);
      bar_len     = 12'($urandom_range(0, 12));
      horz_res    = 12'(hact);
      vert_res    = 12'(lines);
      run_frame(hact, lines, int'($urandom_range(1, 4)), int'($urandom_range(0, 7)), lines / 2);
    end

    // Reset in the middle of an active line.
    solid_color = 12'hA5C;
    for (int x = 0; x < 10; x++) drive(1'b1, 1'b1, x, 0);
    @(posedge pxl_clk);
    #3;
    checking  = 1'b0;
    pxl_rst_n = 1'b0;
    #1;
    chk("midline_reset_rgb", 32'({rgb_red, rgb_green, rgb_blue}), 32'd0);
    chk("midline_reset_de", 32'(rgb_de), 32'd0);
    horz_active  = 1'b0;
    vert_active  = 1'b0;
    frame_active = 1'b0;
    repeat (3) @(posedge pxl_clk);
    exp_q.delete();
    cur_mode = 0;
    frame_no = 0;
    #2;
    pxl_rst_n = 1'b1;
    checking  = 1'b1;
    bar_len   = 12'd5;
    run_frame(30, 5, 2, 1, 2);            // solid again after reset
    run_frame(30, 3, 2, 0, 1);            // bars

    repeat (10) @(posedge pxl_clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
